// File: rtl/rampa_pwm_driver.sv
// Slew-limited PWM driver fed by the ramp FSM's one-hot speed levels.
// Optional build macro SOFT_STOP_EN: level 000 ramps down at the slew rate instead of cutting to 0.
module rampa_pwm_driver #(
    parameter int unsigned PWM_PERIOD = 100,
    parameter int unsigned SLEW_DIV   = 1000,
    parameter int unsigned STEP       = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       lvl_30,
    input  logic       lvl_50,
    input  logic       lvl_100,
    output logic       pwm_out,
    output logic [6:0] duty,
    output logic       at_target,
    output logic       fault
);

    localparam logic [6:0]      T30      = 7'(PWM_PERIOD * 30 / 100);
    localparam logic [6:0]      T50      = 7'(PWM_PERIOD * 50 / 100);
    localparam logic [6:0]      T100     = 7'(PWM_PERIOD);
    localparam logic [6:0]      PwmLast  = 7'(PWM_PERIOD - 1);
    localparam int unsigned     SlewW    = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam logic [SlewW-1:0] SlewLast = SlewW'(SLEW_DIV - 1);

`ifdef SOFT_STOP_EN
    localparam bit HardStop = 1'b0;
`else
    localparam bit HardStop = 1'b1;
`endif

    logic [2:0]       lvl_q;
    logic             fault_q, fault_d;
    logic [SlewW-1:0] slew_cnt_q, slew_cnt_d;
    logic [6:0]       pwm_cnt_q, pwm_cnt_d;
    logic [6:0]       duty_q, duty_d;
    logic [6:0]       duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;
    logic             at_target_q, at_target_d;

    logic       illegal;
    logic [6:0] target_dec, target;
    logic [6:0] up_gap, dn_gap;
    logic       slew_tick, pwm_wrap;

    always_comb begin
        illegal    = 1'b0;
        target_dec = 7'd0;
        unique case (lvl_q)
            3'b000:  target_dec = 7'd0;
            3'b001:  target_dec = T30;
            3'b010:  target_dec = T50;
            3'b100:  target_dec = T100;
            default: illegal = 1'b1;
        endcase
        target  = fault_q ? 7'd0 : target_dec;
        fault_d = fault_q | illegal;

        slew_tick = ena && (slew_cnt_q == SlewLast);
        pwm_wrap  = ena && (pwm_cnt_q == PwmLast);
        up_gap    = target - duty_q;
        dn_gap    = duty_q - target;

        // Fault zeroing has priority over everything, including a coincident tick.
        duty_d = duty_q;
        if (fault_d) begin
            duty_d = 7'd0;
        end else if (HardStop && ena && (lvl_q == 3'b000)) begin
            duty_d = 7'd0;
        end else if (slew_tick) begin
            if (duty_q < target) begin
                duty_d = duty_q + ((32'(up_gap) < STEP) ? up_gap : 7'(STEP));
            end else if (duty_q > target) begin
                duty_d = duty_q - ((32'(dn_gap) < STEP) ? dn_gap : 7'(STEP));
            end
        end

        slew_cnt_d  = slew_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        duty_act_d  = duty_act_q;
        pwm_d       = pwm_q;
        at_target_d = at_target_q;
        if (ena) begin
            slew_cnt_d  = slew_tick ? '0 : slew_cnt_q + 1'b1;
            pwm_cnt_d   = pwm_wrap ? 7'd0 : pwm_cnt_q + 7'd1;
            // Sampled only at the period boundary, so the pre-update duty is taken.
            duty_act_d  = pwm_wrap ? duty_q : duty_act_q;
            pwm_d       = pwm_cnt_q < duty_act_q;
            at_target_d = duty_q == target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_q       <= 3'b000;
            fault_q     <= 1'b0;
            slew_cnt_q  <= '0;
            pwm_cnt_q   <= 7'd0;
            duty_q      <= 7'd0;
            duty_act_q  <= 7'd0;
            pwm_q       <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            lvl_q       <= {lvl_100, lvl_50, lvl_30};
            fault_q     <= fault_d;
            slew_cnt_q  <= slew_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            duty_q      <= duty_d;
            duty_act_q  <= duty_act_d;
            pwm_q       <= pwm_d;
            at_target_q <= at_target_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign duty      = duty_q;
    assign at_target = at_target_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_rampa_pwm_driver.sv
// Directed bench for rampa_pwm_driver (default build, PWM_PERIOD=10, SLEW_DIV=4, STEP=1).
module tb_rampa_pwm_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       lvl_30 = 1'b0;
    logic       lvl_50 = 1'b0;
    logic       lvl_100 = 1'b0;
    logic       pwm_out;
    logic [6:0] duty;
    logic       at_target;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rampa_pwm_driver #(
        .PWM_PERIOD(10),
        .SLEW_DIV  (4),
        .STEP      (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .lvl_30   (lvl_30),
        .lvl_50   (lvl_50),
        .lvl_100  (lvl_100),
        .pwm_out  (pwm_out),
        .duty     (duty),
        .at_target(at_target),
        .fault    (fault)
    );

    typedef struct {
        logic       rst_n;
        logic       ena;
        logic [2:0] lvl;
        int         n;
        int         exp_duty;
        int         exp_at;
        int         exp_fault;
        int         exp_pwm;
        int         exp_hi;   // pwm_out high count over the n edges; -1 skips
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n edges, sampling 1 time unit after each, and count pwm_out highs.
    task automatic run_n(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            hi += int'(pwm_out);
        end
    endtask

    task automatic set_lvl(input logic [2:0] l);
        {lvl_100, lvl_50, lvl_30} = l;
    endtask

    task automatic do_reset();
        int hi;
        rst_n = 1'b0;
        ena   = 1'b1;
        set_lvl(3'b000);
        run_n(1, hi);
        rst_n = 1'b1;
    endtask

    initial begin
        int hi;
        int acc;

        // rst, ena, lvl, n, duty, at, fault, pwm, hi
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 3,  0,  1, 0, 0, -1};
        vecs[1]  = '{1'b1, 1'b1, 3'b001, 3,  0,  0, 0, 0,  0};
        vecs[2]  = '{1'b1, 1'b1, 3'b001, 1,  1,  0, 0, 0, -1};
        vecs[3]  = '{1'b1, 1'b1, 3'b001, 8,  3,  0, 0, 1,  2};
        vecs[4]  = '{1'b1, 1'b1, 3'b001, 1,  3,  1, 0, 0, -1};
        vecs[5]  = '{1'b1, 1'b1, 3'b001, 7,  3,  1, 0, 0,  0};
        vecs[6]  = '{1'b1, 1'b1, 3'b001, 10, 3,  1, 0, 0,  3};
        vecs[7]  = '{1'b1, 1'b1, 3'b100, 2,  4,  0, 0, 1,  2};
        vecs[8]  = '{1'b1, 1'b1, 3'b100, 24, 10, 0, 0, 1, -1};
        vecs[9]  = '{1'b1, 1'b1, 3'b100, 1,  10, 1, 0, 1, -1};
        vecs[10] = '{1'b1, 1'b1, 3'b100, 3,  10, 1, 0, 0, -1};
        vecs[11] = '{1'b1, 1'b1, 3'b100, 20, 10, 1, 0, 1, 20};
        vecs[12] = '{1'b1, 1'b1, 3'b110, 1,  10, 1, 0, 1, -1};
        vecs[13] = '{1'b1, 1'b1, 3'b100, 1,  0,  0, 1, 1, -1};

        // Ramp to 30 %, then 100 %, then an illegal 110 code.
        for (int i = 0; i < 14; i++) begin
            rst_n = vecs[i].rst_n;
            ena   = vecs[i].ena;
            set_lvl(vecs[i].lvl);
            run_n(vecs[i].n, hi);
            check($sformatf("v%0d duty", i), int'(duty), vecs[i].exp_duty);
            check($sformatf("v%0d at_target", i), int'(at_target), vecs[i].exp_at);
            check($sformatf("v%0d fault", i), int'(fault), vecs[i].exp_fault);
            check($sformatf("v%0d pwm_out", i), int'(pwm_out), vecs[i].exp_pwm);
            if (vecs[i].exp_hi >= 0) check($sformatf("v%0d pwm_high_count", i), hi, vecs[i].exp_hi);
        end

        // Illegal 011 at duty 5; tick and PWM wrap coincide on the 20th edge.
        do_reset();
        set_lvl(3'b010);
        run_n(20, hi);
        check("s3 duty_before", int'(duty), 5);
        set_lvl(3'b011);
        run_n(1, hi);
        acc = hi;
        check("s3 fault_lat1", int'(fault), 0);
        check("s3 duty_lat1", int'(duty), 5);
        run_n(1, hi);
        acc += hi;
        check("s3 fault_set", int'(fault), 1);
        check("s3 duty_zeroed", int'(duty), 0);
        set_lvl(3'b010);
        run_n(8, hi);
        acc += hi;
        check("s3 pre_update_duty_act_highs", acc, 4);
        check("s3 fault_sticky", int'(fault), 1);
        check("s3 at_target", int'(at_target), 1);
        run_n(10, hi);
        check("s3 pwm_low_period", hi, 0);
        check("s3 fault_still", int'(fault), 1);
        check("s3 duty_held0", int'(duty), 0);
        do_reset();
        check("s3 fault_cleared", int'(fault), 0);

        // Level 000 from duty 5 cuts duty without slewing.
        set_lvl(3'b010);
        run_n(20, hi);
        set_lvl(3'b000);
        run_n(1, hi);
        check("s4 duty_lat1", int'(duty), 5);
        run_n(1, hi);
        check("s4 duty_cut", int'(duty), 0);
        run_n(8, hi);
        run_n(10, hi);
        check("s4 pwm_low_period", hi, 0);
        check("s4 at_target", int'(at_target), 1);

        // Freeze with ena low at duty 2.
        do_reset();
        set_lvl(3'b010);
        run_n(11, hi);
        check("s5 duty_pre", int'(duty), 2);
        check("s5 pwm_pre", int'(pwm_out), 1);
        ena = 1'b0;
        run_n(20, hi);
        check("s5 frozen_duty", int'(duty), 2);
        check("s5 frozen_pwm_highs", hi, 20);
        check("s5 frozen_at", int'(at_target), 0);
        ena = 1'b1;
        run_n(1, hi);
        check("s5 resume_duty", int'(duty), 3);
        check("s5 resume_pwm", int'(pwm_out), 1);
        run_n(1, hi);
        check("s5 pwm_cnt_kept", int'(pwm_out), 0);

        // Reset mid-ramp at duty 4, mid-period.
        run_n(3, hi);
        check("s6 duty_pre", int'(duty), 4);
        rst_n = 1'b0;
        run_n(1, hi);
        check("s6 duty_rst", int'(duty), 0);
        check("s6 at_rst", int'(at_target), 1);
        check("s6 pwm_rst", int'(pwm_out), 0);
        check("s6 fault_rst", int'(fault), 0);
        rst_n = 1'b1;
        run_n(3, hi);
        check("s6 slew_cnt_cleared", int'(duty), 0);
        run_n(1, hi);
        check("s6 first_tick", int'(duty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
